// File: rtl/controller_modulo_if.sv
// Control bus between the modulo sequencer and its datapath / requester.
// Handshake: start_i is a level request that the controller samples only
// while idle; done_o (with err_o) is a single-cycle completion pulse, and
// busy_o is high from the cycle after start_i is accepted until the cycle
// after done_o. There is no back-pressure: no request is queued while busy.
interface controller_modulo_if;
  logic       start_i;
  logic       valid_i;
  logic [2:0] alu_mode_o;
  logic       wren_update_Zahlen_o;
  logic       wren_Zahl1_to_erg_o;
  logic       wren_res_to_erg_o;
  logic       wren_term_erg_o;
  logic       erg_to_alu_a_o;
  logic       Zahl2_to_alu_b_o;
  logic       check_for_termination_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;
  logic [3:0] state_o;

  // Controller side
  modport slave (
    input  start_i, valid_i,
    output alu_mode_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o,
           wren_res_to_erg_o, wren_term_erg_o, erg_to_alu_a_o,
           Zahl2_to_alu_b_o, check_for_termination_o, busy_o, done_o,
           err_o, state_o
  );

  // Requester / datapath side
  modport master (
    output start_i, valid_i,
    input  alu_mode_o, wren_update_Zahlen_o, wren_Zahl1_to_erg_o,
           wren_res_to_erg_o, wren_term_erg_o, erg_to_alu_a_o,
           Zahl2_to_alu_b_o, check_for_termination_o, busy_o, done_o,
           err_o, state_o
  );
endinterface

// File: rtl/controller_modulo.sv
// Sequencer for a subtract-until-less-than modulo datapath.
// Flow: LOAD operands, copy Zahl1 into the result, then loop
// {compare erg<Zahl2, write termination bit, check, subtract, write back}
// until the datapath reports termination or the iteration limit is hit.
// Outputs are a pure decode of the current state (Moore), so after a reset
// edge every output is 0. state_o exposes the FSM encoding for debug.
module controller_modulo #(
  parameter int unsigned ALU_LAT  = 2,
  parameter logic [15:0] MAX_ITER = 16'hFFFF
) (
  input logic               clk,
  input logic               rst_ni,
  controller_modulo_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_INIT    = 4'd2,
    S_CMP     = 4'd3,
    S_TERM_WB = 4'd4,
    S_CHECK   = 4'd5,
    S_SUB     = 4'd6,
    S_SUB_WB  = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  localparam logic [2:0] ALU_OP_NOP = 3'd0;
  localparam logic [2:0] ALU_OP_SUB = 3'd1;
  localparam logic [2:0] ALU_OP_LT  = 3'd2;

  // Last wait-counter value of a CMP/SUB phase (ALU_LAT cycles long).
  localparam logic [2:0] LAT_LAST  = 3'(ALU_LAT - 1);
  // LOAD lasts two cycles so the datapath input register is covered.
  localparam logic [2:0] LOAD_LAST = 3'd1;

  state_e      state_q, state_d;
  logic [2:0]  wait_q, wait_d;
  logic [15:0] iter_q, iter_d;
  logic        err_q, err_d;

  logic [2:0]  alu_mode;
  logic        wren_update_zahlen;
  logic        wren_zahl1_to_erg;
  logic        wren_res_to_erg;
  logic        wren_term_erg;
  logic        erg_to_alu_a;
  logic        zahl2_to_alu_b;
  logic        check_for_termination;
  logic        done;
  logic        err;

  // State, wait counter, iteration counter and error flag registers.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wait_q  <= 3'd0;
      iter_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and per-state output decode.
  always_comb begin
    state_d               = state_q;
    wait_d                = wait_q;
    iter_d                = iter_q;
    err_d                 = err_q;
    alu_mode              = ALU_OP_NOP;
    wren_update_zahlen    = 1'b0;
    wren_zahl1_to_erg     = 1'b0;
    wren_res_to_erg       = 1'b0;
    wren_term_erg         = 1'b0;
    erg_to_alu_a          = 1'b0;
    zahl2_to_alu_b        = 1'b0;
    check_for_termination = 1'b0;
    done                  = 1'b0;
    err                   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_LOAD;
          wait_d  = 3'd0;
          iter_d  = 16'd0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        wren_update_zahlen = 1'b1;
        if (wait_q == LOAD_LAST) begin
          wait_d  = 3'd0;
          state_d = S_INIT;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_INIT: begin
        wren_zahl1_to_erg = 1'b1;
        wait_d            = 3'd0;
        state_d           = S_CMP;
      end

      S_CMP: begin
        alu_mode       = ALU_OP_LT;
        erg_to_alu_a   = 1'b1;
        zahl2_to_alu_b = 1'b1;
        if (wait_q == LAT_LAST) begin
          wait_d  = 3'd0;
          state_d = S_TERM_WB;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_TERM_WB: begin
        alu_mode       = ALU_OP_LT;
        erg_to_alu_a   = 1'b1;
        zahl2_to_alu_b = 1'b1;
        wren_term_erg  = 1'b1;
        state_d        = S_CHECK;
      end

      S_CHECK: begin
        check_for_termination = 1'b1;
        wait_d                = 3'd0;
        if (bus.valid_i) begin
          state_d = S_DONE;
        end else if (iter_q == MAX_ITER) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
        end
      end

      S_SUB: begin
        alu_mode       = ALU_OP_SUB;
        erg_to_alu_a   = 1'b1;
        zahl2_to_alu_b = 1'b1;
        if (wait_q == LAT_LAST) begin
          wait_d  = 3'd0;
          state_d = S_SUB_WB;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end

      S_SUB_WB: begin
        alu_mode        = ALU_OP_SUB;
        erg_to_alu_a    = 1'b1;
        zahl2_to_alu_b  = 1'b1;
        wren_res_to_erg = 1'b1;
        // Saturate: the counter must never wrap back below MAX_ITER.
        if (iter_q != 16'hFFFF) begin
          iter_d = iter_q + 16'd1;
        end
        wait_d  = 3'd0;
        state_d = S_CMP;
      end

      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        wait_d  = 3'd0;
        iter_d  = 16'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign bus.alu_mode_o              = alu_mode;
  assign bus.wren_update_Zahlen_o    = wren_update_zahlen;
  assign bus.wren_Zahl1_to_erg_o     = wren_zahl1_to_erg;
  assign bus.wren_res_to_erg_o       = wren_res_to_erg;
  assign bus.wren_term_erg_o         = wren_term_erg;
  assign bus.erg_to_alu_a_o          = erg_to_alu_a;
  assign bus.Zahl2_to_alu_b_o        = zahl2_to_alu_b;
  assign bus.check_for_termination_o = check_for_termination;
  assign bus.busy_o                  = (state_q != S_IDLE);
  assign bus.done_o                  = done;
  assign bus.err_o                   = err;
  assign bus.state_o                 = state_q;

endmodule

// File: doc/controller_modulo.md
CONTROLLER_MODULO -- requirements
Module: controller_modulo

Interface
REQ-001 Parameter ALU_LAT, default 2, cycles from operand select to result valid on the datapath write-back bus (legal range 1..7).
REQ-002 Parameter MAX_ITER, default 16'hFFFF, maximum subtraction iterations before abort.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  synchronous active-low reset.
REQ-006 start_i  input  1  request one modulo operation; sampled only in IDLE.
REQ-007 valid_i  input  1  datapath termination indication (check qualified AND termination register).
REQ-008 alu_mode_o  output  3  ALU opcode: 3'd0 NOP, 3'd1 SUB (a-b), 3'd2 LT (bit0 = a<b unsigned).
REQ-009 wren_update_Zahlen_o  output  1  load operand registers from datapath inputs.
REQ-010 wren_Zahl1_to_erg_o  output  1  copy Zahl1 into result register.
REQ-011 wren_res_to_erg_o  output  1  write ALU result into result register.
REQ-012 wren_term_erg_o  output  1  write ALU result bit0 into termination register.
REQ-013 erg_to_alu_a_o  output  1  result register drives ALU operand a.
REQ-014 Zahl2_to_alu_b_o  output  1  Zahl2 register drives ALU operand b.
REQ-015 check_for_termination_o  output  1  qualify valid_i.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 done_o  output  1  one-cycle pulse at operation end.
REQ-018 err_o  output  1  one-cycle pulse, coincident with done_o, on iteration abort.

Function
REQ-019 States: IDLE, LOAD, INIT, CMP, TERM_WB, CHECK, SUB, SUB_WB, DONE; state register is the only control memory besides wait counter (3 bit) and iteration counter (16 bit).
REQ-020 IDLE: all outputs 0; start_i=1 -> LOAD, clear iteration counter.
REQ-021 LOAD: 2 cycles, wren_update_Zahlen_o=1 both cycles (covers datapath input register) -> INIT.
REQ-022 INIT: 1 cycle, wren_Zahl1_to_erg_o=1 -> CMP.
REQ-023 CMP: ALU_LAT cycles, alu_mode_o=LT, erg_to_alu_a_o=1, Zahl2_to_alu_b_o=1 -> TERM_WB.
REQ-024 TERM_WB: 1 cycle, same mode/selects held, wren_term_erg_o=1 -> CHECK.
REQ-025 CHECK: 1 cycle, check_for_termination_o=1; valid_i=1 -> DONE; else iteration counter = MAX_ITER -> DONE with error flag; else -> SUB.
REQ-026 SUB: ALU_LAT cycles, alu_mode_o=SUB, both selects=1 -> SUB_WB.
REQ-027 SUB_WB: 1 cycle, mode/selects held, wren_res_to_erg_o=1, iteration counter +1 -> CMP.
REQ-028 DONE: 1 cycle, done_o=1, err_o=error flag, all write enables 0 -> IDLE; start_i in DONE ignored.
REQ-029 At most one wren_* output high in any cycle; alu_mode_o and selects stable throughout each CMP/TERM_WB and SUB/SUB_WB pair.
REQ-030 start_i while busy_o=1 ignored; no queuing.
REQ-031 Iteration counter saturates, never wraps; Zahl2=0 terminates only via MAX_ITER abort.
REQ-032 Total latency, start sample to done_o: 3 + 4*(k+1) + 3*k + 1 cycles for ALU_LAT=2, k = subtraction count.

Reset
REQ-033 rst_ni=0 at a rising edge -> IDLE, counters 0, error flag 0; all outputs 0 from the following cycle.
REQ-034 Reset mid-operation aborts without done_o or err_o; next start_i after release begins a fresh operation.

Verification
REQ-035 Zahl1=17, Zahl2=5, ALU_LAT=2 -> 3 SUB_WB pulses, done_o in 29th cycle after start, err_o=0, datapath ergebnis=2.
REQ-036 Zahl1=3, Zahl2=7 -> no SUB entered, done_o in 8th cycle, ergebnis=3.
REQ-037 Zahl2=0, MAX_ITER=8 -> 8 SUB_WB pulses, done_o=1 and err_o=1 same cycle, then IDLE.
REQ-038 start_i held high through operation 17 mod 5 -> exactly one done_o per IDLE entry; second op starts only after IDLE.
REQ-039 rst_ni=0 during SUB of 17 mod 5 -> next cycle all outputs 0, busy_o=0, no done_o; subsequent 17 mod 5 completes normally.
REQ-040 Assertion over all tests: at most one wren_* high per cycle; done_o never two consecutive cycles.
